nib_gather: RTL
===============

# nib_gather

Nibble gatherer for the nm2 nibble datapath. It collects a serial stream of 4-bit nibbles from a valid/ready source and presents each group of four as the parallel bus `nibble_A`..`nibble_D` with a valid/ready handshake. It is the producer-side counterpart of the blocks that consume four parallel nibbles. It also reports the word XOR checksum, a short-word flag, and a running word count.

## Interface
- `FIRST_IS_A`, default 1: 1 puts the first-received nibble on `nibble_A`; 0 puts it on `nibble_D` (reverse order).
- `CNT_W`, default 8: width of `word_cnt`.

- `clk`, input, 1: rising-edge clock, the only clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `in_nibble` is valid.
- `in_nibble`, input, 4: serial nibble.
- `in_last`, input, 1: qualified by `in_valid`; the nibble is the final one of a frame.
- `in_ready`, output, 1: the block accepts a nibble this cycle.
- `nibble_A`..`nibble_D`, output, 4 each: assembled word.
- `out_valid`, output, 1: word held on the outputs.
- `out_ready`, input, 1: the sink takes the word this cycle.
- `out_short`, output, 1: the word was closed by `in_last` before 4 nibbles.
- `out_xor`, output, 4: XOR of the four output nibbles, including padding.
- `word_cnt`, output, `CNT_W`: number of words handed off (`out_valid && out_ready`); wraps modulo 2^`CNT_W`.

## Operation
- A nibble is accepted when `in_valid && in_ready`. A word is handed off when `out_valid && out_ready`.
- States:
  - COLLECT: slot counter `idx` runs 0..3.
  - HOLD: word complete, `out_valid` = 1.
- COLLECT behaviour:
  - Each accepted nibble is written to slot `idx`. Slot order is A,B,C,D, or D,C,B,A when `FIRST_IS_A` = 0.
  - `idx` increments on each accepted nibble.
  - Go to HOLD when the accepted nibble has `idx` = 3 or `in_last` = 1.
- Short word: a word closed by `in_last` with `idx` < 3.
  - Unfilled slots are written 0.
  - `out_short` = 1 for that word; otherwise `out_short` = 0.
- `in_ready` = (state == COLLECT) || `out_ready`.
- HOLD behaviour:
  - Outputs are stable until handoff.
  - On handoff with no simultaneous acceptance: return to COLLECT with `idx` = 0.
  - On handoff with a simultaneous acceptance: that nibble goes to slot 0 of the new word, `idx` = 1, state = COLLECT. If that nibble also has `in_last`, it forms a short word and the state stays HOLD.
- The assembly register is separate from the output register. The output register loads only on word close, so the outputs do not change while collecting the next word.
- `out_xor` is registered together with the output nibbles.
- `word_cnt` increments on handoff and wraps from 2^`CNT_W`−1 to 0.
- An `in_last` with `idx` = 3 closes a normal full word (`out_short` = 0).

## Timing
- Reset values: `out_valid` = 0, `nibble_A`..`nibble_D` = 0, `out_xor` = 0, `out_short` = 0, `word_cnt` = 0, state = COLLECT, `idx` = 0, assembly register = 0.
- `in_ready` is combinational, so it reads 1 during reset.
- Latency: `out_valid` rises on the clock edge that accepts the closing nibble. Outputs are valid the cycle after that nibble is presented.
- Throughput: with `out_ready` held at 1, one nibble is accepted per cycle and one word is produced every 4 cycles with no bubbles.
- `reset` asserted mid-word or in HOLD clears everything at once, independent of the clock. The partial word is discarded and not counted.
- `in_valid` low for any number of cycles in COLLECT holds `idx` and the partial word.

## Structure
- Shared package `nib_pkg`:
  - state enum `{COLLECT, HOLD}`
  - `NIB_W` = 4
  - `NIB_PER_WORD` = 4
- One sub-module is natural: `nib_slot_dec`, which maps `idx` plus `FIRST_IS_A` to a one-hot slot write-enable.
- Everything else lives in one sequential process plus the `in_ready` assign.

## Test plan
- Reset, then stream 1,2,3,4 with `out_ready` = 1 → A=1, B=2, C=3, D=4, `out_xor` = 4, `out_short` = 0, `out_valid` for 1 cycle, `word_cnt` = 1.
- `FIRST_IS_A` = 0, stream 1,5,3,4 → A=4, B=3, C=5, D=1, `out_xor` = 3.
- Stream 8,5 with `in_last` on the 5 → A=8, B=5, C=0, D=0, `out_short` = 1, `out_xor` = 0xD.
- Back-to-back words with `out_ready` = 0 for 3 cycles after the first word closes:
  - `in_ready` = 0 and outputs stable during the stall.
  - On release, the next nibble is accepted in the same cycle as handoff.
  - The second word is correct, and `word_cnt` advances by exactly 1 per handoff.
- Assert `reset` asynchronously (between clock edges) after 2 nibbles, then send 1,2,3,4 → all outputs are 0 immediately, and the first word after reset is exactly 1,2,3,4.
- `CNT_W` = 2, hand off 5 words → `word_cnt` reads 1,2,3,0,1.

Source files
------------

// File: rtl/nib_pkg.sv
// Shared types and constants for the nm2 nibble datapath.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package nib_pkg;

  localparam int NIB_W        = 4;
  localparam int NIB_PER_WORD = 4;
  localparam int IDX_W        = $clog2(NIB_PER_WORD);

  typedef logic [NIB_W-1:0] nib_t;

  // Slot 0 is nibble_A, slot NIB_PER_WORD-1 is nibble_D.
  typedef nib_t [NIB_PER_WORD-1:0] word_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // XOR of every nibble of a word, padding included.
  function automatic nib_t word_xor(input word_t w);
    nib_t acc;
    acc = '0;
    for (int s = 0; s < NIB_PER_WORD; s++) begin
      acc = acc ^ w[s];
    end
    return acc;
  endfunction

endpackage

// File: rtl/nib_slot_dec.sv
// Maps the fill index to a one-hot slot write-enable, honouring the fill order.
// Latency: purely combinational.
// Backpressure: none; en gates the enable so nothing is written unless a nibble is accepted.
module nib_slot_dec
  import nib_pkg::*;
#(
  parameter int FIRST_IS_A = 1
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic                    en,
  output logic [NIB_PER_WORD-1:0] slot_we
);

  logic [IDX_W-1:0] slot;

  // Forward order fills A first; reverse order fills D first.
  always_comb begin
    slot    = (FIRST_IS_A != 0) ? idx : (IDX_W'(NIB_PER_WORD - 1) - idx);
    slot_we = '0;
    if (en) begin
      slot_we[slot] = 1'b1;
    end
  end

endmodule

// File: rtl/nib_gather.sv
// Gathers four serial nibbles into one parallel word with xor, short flag and word count.
// Latency: out_valid rises on the edge that accepts the closing nibble.
// Backpressure: in_ready drops only while a word is held and the sink is not ready.
module nib_gather
  import nib_pkg::*;
#(
  parameter int FIRST_IS_A = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [NIB_W-1:0] in_nibble,
  input  logic             in_last,
  output logic             in_ready,
  output logic [NIB_W-1:0] nibble_A,
  output logic [NIB_W-1:0] nibble_B,
  output logic [NIB_W-1:0] nibble_C,
  output logic [NIB_W-1:0] nibble_D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_short,
  output logic [NIB_W-1:0] out_xor,
  output logic [CNT_W-1:0] word_cnt
);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  word_t                   asm_q, asm_nxt;
  word_t                   merged;
  word_t                   out_word_q;
  logic [NIB_PER_WORD-1:0] slot_we;
  logic                    accept;
  logic                    handoff;
  logic                    close_word;

  // The sink being ready frees the held word this cycle, so a nibble can be
  // taken in the same cycle as the handoff.
  assign in_ready   = (state == COLLECT) || out_ready;
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid && in_ready;
  assign handoff    = out_valid && out_ready;
  assign close_word = accept && ((idx == IDX_W'(NIB_PER_WORD - 1)) || in_last);

  assign nibble_A = out_word_q[0];
  assign nibble_B = out_word_q[1];
  assign nibble_C = out_word_q[2];
  assign nibble_D = out_word_q[3];

  nib_slot_dec #(
    .FIRST_IS_A(FIRST_IS_A)
  ) u_slot_dec (
    .idx    (idx),
    .en     (accept),
    .slot_we(slot_we)
  );

  // Assembly word with the incoming nibble merged into its slot. The assembly
  // register is cleared on every close, so unfilled slots of a short word are 0.
  always_comb begin
    merged = asm_q;
    for (int s = 0; s < NIB_PER_WORD; s++) begin
      if (slot_we[s]) begin
        merged[s] = in_nibble;
      end
    end
  end

  // Next-state: a close always lands in HOLD (also when it coincides with a
  // handoff); an accepted non-closing nibble keeps or returns us to COLLECT.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    asm_nxt   = asm_q;
    if (accept) begin
      if (close_word) begin
        state_nxt = HOLD;
        idx_nxt   = '0;
        asm_nxt   = '0;
      end else begin
        state_nxt = COLLECT;
        idx_nxt   = idx + IDX_W'(1);
        asm_nxt   = merged;
      end
    end else if (handoff) begin
      state_nxt = COLLECT;
    end
  end

  // State, fill index and assembly register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
      idx   <= '0;
      asm_q <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      asm_q <= asm_nxt;
    end
  end

  // Output register loads only on close so it stays put while the next word fills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_word_q <= '0;
      out_xor    <= '0;
      out_short  <= 1'b0;
    end else if (close_word) begin
      out_word_q <= merged;
      out_xor    <= word_xor(merged);
      out_short  <= (idx != IDX_W'(NIB_PER_WORD - 1));
    end
  end

  // Count of words taken by the sink; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (handoff) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule
